// File: rtl/seq_mod_multi.sv
// rtl/seq_mod_multi.sv - multi-phase modulo sequencer with a programmable terminal-value table
module seq_mod_multi #(
    parameter int WIDTH     = 3,
    parameter int PHASES    = 4,
    parameter int PW        = 2,
    parameter int BASE_TERM = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PW-1:0]    last_phase,
    input  logic             cfg_we,
    input  logic [PW-1:0]    cfg_idx,
    input  logic [WIDTH-1:0] cfg_term,
    output logic [WIDTH-1:0] count,
    output logic [PW-1:0]    phase,
    output logic             tc,
    output logic             seq_done
);

    logic [WIDTH-1:0] r_term [PHASES];
    logic [WIDTH-1:0] r_count;
    logic [PW-1:0]    r_phase;

    logic [WIDTH-1:0] w_cur_term;
    logic             w_hit;
    logic             w_tc;
    logic             w_last;
    logic             w_wrap;

    // Look up the terminal value of the current phase; a mux loop keeps
    // out-of-range phase codes (non power-of-two PHASES) well defined.
    always_comb begin
        w_cur_term = r_term[0];
        for (int i = 1; i < PHASES; i++) begin
            if (r_phase == PW'(i)) begin
                w_cur_term = r_term[i];
            end
        end
    end

    // A ">=" compare means a term lowered below the running count wraps at
    // once instead of counting on towards overflow.
    assign w_hit  = (r_count >= w_cur_term);
    assign w_tc   = en & ~clr & w_hit;
    assign w_last = (r_phase >= last_phase);
    // Also wrap at the top table slot so last_phase >= PHASES cannot walk
    // the phase index off the end of the table.
    assign w_wrap = w_last | (r_phase == PW'(PHASES - 1));

    assign count    = r_count;
    assign phase    = r_phase;
    assign tc       = w_tc;
    assign seq_done = w_tc & w_last;

    // Count and phase sequencing: clear beats enable, terminal hit wraps the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_phase <= '0;
        end else if (clr) begin
            r_count <= '0;
            r_phase <= '0;
        end else if (en) begin
            if (w_hit) begin
                r_count <= '0;
                r_phase <= w_wrap ? '0 : r_phase + PW'(1);
            end else begin
                r_count <= r_count + WIDTH'(1);
            end
        end
    end

    // Terminal table: reset to BASE_TERM+i, rewritten by the cfg strobe at any time;
    // indices with no matching slot simply match nothing and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHASES; i++) begin
                r_term[i] <= WIDTH'(BASE_TERM + i);
            end
        end else if (cfg_we) begin
            for (int i = 0; i < PHASES; i++) begin
                if (cfg_idx == PW'(i)) begin
                    r_term[i] <= cfg_term;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_mod_multi.sv
// tb/tb_seq_mod_multi.sv - self-checking bench for seq_mod_multi
module tb_seq_mod_multi;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic [1:0] last_phase;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [2:0] cfg_term;
    logic [2:0] count;
    logic [1:0] phase;
    logic       tc;
    logic       seq_done;

    seq_mod_multi #(
        .WIDTH(3), .PHASES(4), .PW(2), .BASE_TERM(3)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .last_phase(last_phase),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_term(cfg_term),
        .count(count), .phase(phase), .tc(tc), .seq_done(seq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: plain integers, phase length = term+1 enabled cycles
    int m_term [4];
    int m_count;
    int m_phase;

    // DUT values sampled in the last step (before its active edge)
    int s_count, s_phase, s_tc, s_done;

    typedef struct {
        logic       en;
        logic [1:0] lp;
        int         exp_count;
        int         exp_phase;
        int         exp_tc;
        int         exp_done;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic model_reset();
        m_count = 0;
        m_phase = 0;
        for (int i = 0; i < 4; i++) m_term[i] = (3 + i) % 8;
    endtask

    // one clock: drive at negedge, check just after, model advances on the edge
    task automatic step(input logic a_en, input logic a_clr, input logic [1:0] a_lp,
                        input logic a_we, input logic [1:0] a_idx, input logic [2:0] a_val);
        int e_tc, e_done;
        en = a_en; clr = a_clr; last_phase = a_lp;
        cfg_we = a_we; cfg_idx = a_idx; cfg_term = a_val;
        #1;
        e_tc   = (a_en && !a_clr && m_count >= m_term[m_phase]) ? 1 : 0;
        e_done = (e_tc == 1 && m_phase >= int'(a_lp)) ? 1 : 0;
        s_count = int'(count);
        s_phase = int'(phase);
        s_tc    = int'(tc);
        s_done  = int'(seq_done);
        chk("model_count", s_count, m_count);
        chk("model_phase", s_phase, m_phase);
        chk("model_tc", s_tc, e_tc);
        chk("model_seq_done", s_done, e_done);
        @(posedge clk);
        if (a_clr) begin
            m_count = 0;
            m_phase = 0;
        end else if (a_en) begin
            if (e_tc == 1) begin
                m_count = 0;
                m_phase = (m_phase >= int'(a_lp)) ? 0 : m_phase + 1;
            end else begin
                m_count = m_count + 1;
            end
        end
        if (a_we) m_term[a_idx] = int'(a_val);
        @(negedge clk);
    endtask

    task automatic run_until(input logic [1:0] lp, input int ph, input int cnt, input int budget);
        int k;
        k = 0;
        while (!(m_phase == ph && m_count == cnt) && k < budget) begin
            step(1'b1, 1'b0, lp, 1'b0, 2'd0, 3'd0);
            k++;
        end
        chk("reach_target_in_budget", (m_phase == ph && m_count == cnt) ? 1 : 0, 1);
    endtask

    // default table with last_phase=3: phases of 4,5,6,7 cycles, seq_done once per 22
    task automatic period_check(input string nm);
        int n_done, first, second;
        n_done = 0; first = -1; second = -1;
        step(1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 3'd0);
        for (int k = 0; k < 44; k++) begin
            step(1'b1, 1'b0, 2'd3, 1'b0, 2'd0, 3'd0);
            if (s_done == 1) begin
                if (n_done == 0) first = k;
                else if (n_done == 1) second = k;
                n_done++;
            end
        end
        chk({nm, "_done_count"}, n_done, 2);
        chk({nm, "_first_done"}, first, 21);
        chk({nm, "_second_done"}, second, 43);
    endtask

    initial begin
        int seen3;
        logic [1:0] r_lp;

        vecs[0] = '{1'b1, 2'd1, 0, 0, 0, 0};
        vecs[1] = '{1'b1, 2'd1, 1, 0, 0, 0};
        vecs[2] = '{1'b1, 2'd1, 2, 0, 0, 0};
        vecs[3] = '{1'b1, 2'd1, 3, 0, 1, 0};
        vecs[4] = '{1'b1, 2'd1, 0, 1, 0, 0};
        vecs[5] = '{1'b1, 2'd1, 1, 1, 0, 0};
        vecs[6] = '{1'b1, 2'd1, 2, 1, 0, 0};
        vecs[7] = '{1'b1, 2'd1, 3, 1, 0, 0};
        vecs[8] = '{1'b1, 2'd1, 4, 1, 1, 1};
        vecs[9] = '{1'b1, 2'd1, 0, 0, 0, 0};

        rst = 1'b1; en = 1'b1; clr = 1'b0; last_phase = 2'd1;
        cfg_we = 1'b0; cfg_idx = 2'd0; cfg_term = 3'd0;
        model_reset();
        #2;
        chk("reset_count", int'(count), 0);
        chk("reset_phase", int'(phase), 0);
        chk("reset_tc", int'(tc), 0);
        chk("reset_seq_done", int'(seq_done), 0);
        @(negedge clk);
        rst = 1'b0;

        // defaults sequence from reset, last_phase=1
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].en, 1'b0, vecs[i].lp, 1'b0, 2'd0, 3'd0);
            chk("vec_count", s_count, vecs[i].exp_count);
            chk("vec_phase", s_phase, vecs[i].exp_phase);
            chk("vec_tc", s_tc, vecs[i].exp_tc);
            chk("vec_seq_done", s_done, vecs[i].exp_done);
        end

        period_check("four_phase");

        // gating and clear
        step(1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 3'd0);
        run_until(2'd1, 1, 2, 20);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 2'd1, 1'b0, 2'd0, 3'd0);
            chk("gate_hold_count", s_count, 2);
            chk("gate_hold_phase", s_phase, 1);
        end
        step(1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 3'd0);
        chk("clr_tc_low", s_tc, 0);
        step(1'b0, 1'b0, 2'd1, 1'b0, 2'd0, 3'd0);
        chk("clr_count", s_count, 0);
        chk("clr_phase", s_phase, 0);

        // reconfiguration: same-cycle compare uses the old term
        run_until(2'd3, 0, 2, 20);
        step(1'b1, 1'b0, 2'd3, 1'b1, 2'd0, 3'd1);
        chk("recfg_old_compare_tc", s_tc, 0);
        step(1'b1, 1'b0, 2'd3, 1'b0, 2'd0, 3'd0);
        chk("recfg_count3", s_count, 3);
        chk("recfg_wrap_tc", s_tc, 1);
        step(1'b0, 1'b0, 2'd3, 1'b1, 2'd2, 3'd0);
        chk("recfg_after_wrap_count", s_count, 0);
        chk("recfg_after_wrap_phase", s_phase, 1);
        run_until(2'd3, 2, 0, 20);
        step(1'b1, 1'b0, 2'd3, 1'b0, 2'd0, 3'd0);
        chk("term0_tc", s_tc, 1);
        step(1'b0, 1'b0, 2'd3, 1'b0, 2'd0, 3'd0);
        chk("term0_next_phase", s_phase, 3);

        // lower last_phase while in phase 2
        step(1'b0, 1'b0, 2'd3, 1'b1, 2'd0, 3'd3);
        step(1'b0, 1'b0, 2'd3, 1'b1, 2'd2, 3'd5);
        step(1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 3'd0);
        run_until(2'd3, 2, 1, 30);
        seen3 = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 3'd0);
            if (s_phase == 3) seen3 = 1;
            if (m_phase != 2) break;
        end
        step(1'b0, 1'b0, 2'd1, 1'b0, 2'd0, 3'd0);
        chk("lp_lower_phase", s_phase, 0);
        chk("lp_lower_no_phase3", seen3, 0);

        // term = 2^WIDTH-1: count reaches 7 then 0
        step(1'b0, 1'b0, 2'd1, 1'b1, 2'd0, 3'd7);
        step(1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 3'd0);
        run_until(2'd1, 0, 7, 20);
        step(1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 3'd0);
        chk("max_term_count", s_count, 7);
        chk("max_term_tc", s_tc, 1);
        step(1'b0, 1'b0, 2'd1, 1'b0, 2'd0, 3'd0);
        chk("max_term_wrap_count", s_count, 0);
        chk("max_term_wrap_phase", s_phase, 1);

        // asynchronous reset mid-phase restores the table
        step(1'b0, 1'b0, 2'd3, 1'b1, 2'd1, 3'd2);
        step(1'b0, 1'b0, 2'd3, 1'b1, 2'd0, 3'd3);
        step(1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 3'd0);
        run_until(2'd3, 2, 3, 40);
        step(1'b0, 1'b0, 2'd3, 1'b0, 2'd0, 3'd0);
        chk("pre_rst_phase", s_phase, 2);
        chk("pre_rst_count", s_count, 3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_phase", int'(phase), 0);
        chk("async_rst_tc", int'(tc), 0);
        chk("async_rst_seq_done", int'(seq_done), 0);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        period_check("post_reset");

        // randomized traffic against the model
        r_lp = 2'd3;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0) r_lp = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 30) == 0), r_lp,
                 ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
